// File: rtl/ps2_host_ctl_if.sv
// Host-side request/status bus of the PS/2 host-to-device command sequencer.
// The master side issues CPU commands, LED updates and raw rx bytes; the slave
// side (the sequencer) returns acknowledges, transfer status and the rx inhibit.
interface ps2_host_ctl_if;
  logic       cpu_req;
  logic [7:0] cpu_cmd;
  logic       cpu_ack;
  logic       led_req;
  logic [2:0] led_val;
  logic       rx_valid;
  logic [7:0] rx_code;
  logic       rx_inhibit;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output cpu_req, cpu_cmd, led_req, led_val, rx_valid, rx_code,
    input  cpu_ack, rx_inhibit, busy, done, err, err_code
  );

  modport slave (
    input  cpu_req, cpu_cmd, led_req, led_val, rx_valid, rx_code,
    output cpu_ack, rx_inhibit, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_host_ctl.sv
// PS/2 host-to-device command sequencer.
// Arbitrates CPU single-byte commands against automatic keyboard-LED updates
// (0xED followed by the LED byte), then runs each byte end to end: clock
// inhibit, request-to-send, bit shifting on device clock falling edges, device
// ACK bit, and the 0xFA / 0xFE reply with bounded resends. The port pins are
// open drain: clk_oe / dat_oe = 1 pull the line low.
module ps2_host_ctl #(
  parameter int INHIBIT_CYC = 1600,
  parameter int TIMEOUT_CYC = 32000,
  parameter int MAX_RETRY   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk_sync,
  input  logic          ps2_dat_sync,
  output logic          clk_oe,
  output logic          dat_oe,
  ps2_host_ctl_if.slave bus
);

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  localparam logic [INH_W-1:0] INH_LOAD  = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(MAX_RETRY);

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RETRY   = 2'd2;
  localparam logic [1:0] ERR_PROTO   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_RTS     = 3'd2,
    S_SHIFT   = 3'd3,
    S_WAITRSP = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_nxt;

  logic             clk_d;
  logic [3:0]       edge_cnt;
  logic             dat_bit;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [RTY_W-1:0] retry;
  logic             led_pend;
  logic             nxt_pend;
  logic             cpu_ack_q;
  logic             done_q;
  logic             err_q;
  logic [1:0]       err_code_q;

  logic [7:0]       tx_byte;
  logic [7:0]       nxt_byte;

  logic             fall;
  logic [3:0]       edge_n;
  logic             led_go;
  logic [RTY_W-1:0] retry_inc;

  logic             accept_led;
  logic             accept_cpu;
  logic             load_next;
  logic             resend;
  logic             finish;
  logic             abort;
  logic [1:0]       abort_code;

  // Falling edge of the device clock: previous level high, current level low.
  assign fall      = clk_d & ~ps2_clk_sync;
  assign edge_n    = edge_cnt + 4'd1;
  // A pulse arriving this very cycle counts as pending so it wins arbitration.
  assign led_go    = led_pend | bus.led_req;
  assign retry_inc = retry + RTY_W'(1);

  // Next-state and transfer-event decode.
  always_comb begin
    state_nxt  = state_q;
    accept_led = 1'b0;
    accept_cpu = 1'b0;
    load_next  = 1'b0;
    resend     = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (led_go) begin
          accept_led = 1'b1;
          state_nxt  = S_INHIBIT;
        end else if (bus.cpu_req) begin
          accept_cpu = 1'b1;
          state_nxt  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == '0) state_nxt = S_RTS;
      end
      S_RTS: begin
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          if (edge_n == 4'd11) begin
            // Edge 11 carries the device ACK bit, driven low by the device.
            if (ps2_dat_sync) begin
              abort      = 1'b1;
              abort_code = ERR_PROTO;
            end else begin
              state_nxt = S_WAITRSP;
            end
          end
        end else if (to_cnt == '0) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      S_WAITRSP: begin
        if (bus.rx_valid) begin
          if (bus.rx_code == RSP_ACK) begin
            if (nxt_pend) begin
              load_next = 1'b1;
              state_nxt = S_INHIBIT;
            end else begin
              finish    = 1'b1;
              state_nxt = S_IDLE;
            end
          end else if (bus.rx_code == RSP_RESEND) begin
            if (retry_inc > RETRY_LIM) begin
              abort      = 1'b1;
              abort_code = ERR_RETRY;
            end else begin
              resend    = 1'b1;
              state_nxt = S_INHIBIT;
            end
          end else begin
            abort      = 1'b1;
            abort_code = ERR_PROTO;
          end
        end else if (to_cnt == '0) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State register and all control counters, pulses and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_d      <= 1'b1;
      edge_cnt   <= 4'd0;
      dat_bit    <= 1'b0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      retry      <= '0;
      led_pend   <= 1'b0;
      nxt_pend   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q   <= state_nxt;
      clk_d     <= ps2_clk_sync;
      led_pend  <= led_go & ~accept_led;
      cpu_ack_q <= accept_cpu;
      done_q    <= finish;
      err_q     <= abort;

      if (accept_led || accept_cpu) err_code_q <= ERR_NONE;
      else if (abort)               err_code_q <= abort_code;

      // The LED byte is queued behind 0xED; a CPU command has no second byte.
      if (accept_led)                    nxt_pend <= 1'b1;
      else if (accept_cpu || load_next)  nxt_pend <= 1'b0;

      // Resend budget is per byte, so it restarts for the queued LED byte too.
      if (accept_led || accept_cpu || load_next) retry <= '0;
      else if (resend)                           retry <= retry_inc;

      if (accept_led || accept_cpu || load_next || resend) inh_cnt <= INH_LOAD;
      else if (state_q == S_INHIBIT && inh_cnt != '0)      inh_cnt <= inh_cnt - INH_W'(1);

      if (state_q == S_RTS) begin
        edge_cnt <= 4'd0;
        dat_bit  <= 1'b1;
      end else if (state_q == S_SHIFT && fall) begin
        edge_cnt <= edge_n;
        if (edge_n <= 4'd8)       dat_bit <= ~tx_byte[edge_cnt[2:0]];
        else if (edge_n == 4'd9)  dat_bit <= ^tx_byte;
        else                      dat_bit <= 1'b0;
      end

      // Reloaded on entry to SHIFT and on every falling edge; edge 11 is also
      // the entry to WAITRSP, so the reply window starts fresh.
      if (state_q == S_RTS || (state_q == S_SHIFT && fall)) to_cnt <= TO_LOAD;
      else if (to_cnt != '0)                                to_cnt <= to_cnt - TO_W'(1);
    end
  end

  // Byte holding registers; only meaningful after an accept, so no reset.
  always_ff @(posedge clk) begin
    if (accept_led) begin
      tx_byte  <= CMD_SET_LED;
      nxt_byte <= {5'b0, bus.led_val};
    end else if (accept_cpu) begin
      tx_byte  <= bus.cpu_cmd;
    end else if (load_next) begin
      tx_byte  <= nxt_byte;
    end
  end

  // Line drivers are decoded from state, so any exit to IDLE releases both.
  assign clk_oe         = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign dat_oe         = (state_q == S_RTS) || ((state_q == S_SHIFT) && dat_bit);
  assign bus.rx_inhibit = (state_q == S_INHIBIT) || (state_q == S_RTS) ||
                          (state_q == S_SHIFT);
  assign bus.busy       = (state_q == S_INHIBIT) || (state_q == S_RTS) ||
                          (state_q == S_SHIFT)   || (state_q == S_WAITRSP);
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_ctl.sv
// Directed bench for ps2_host_ctl: a behavioural PS/2 device drives the clock,
// reads the host bits on the open-drain lines, drives the ACK bit and replies
// through the rx path.
module tb_ps2_host_ctl;
  localparam int INH = 20;
  localparam int TO  = 300;
  localparam int MR  = 3;

  logic clk;
  logic rst;
  logic dev_clk;
  logic dev_dat;
  logic ps2_clk_sync;
  logic ps2_dat_sync;
  logic clk_oe;
  logic dat_oe;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_ack  = 0;

  ps2_host_ctl_if bus ();

  ps2_host_ctl #(
    .INHIBIT_CYC (INH),
    .TIMEOUT_CYC (TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_sync (ps2_clk_sync),
    .ps2_dat_sync (ps2_dat_sync),
    .clk_oe       (clk_oe),
    .dat_oe       (dat_oe),
    .bus          (bus)
  );

  // Wired-AND open-drain lines.
  assign ps2_clk_sync = dev_clk & ~clk_oe;
  assign ps2_dat_sync = dev_dat & ~dat_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.done)    n_done++;
    if (bus.err)     n_err++;
    if (bus.cpu_ack) n_ack++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bench cycle; a CPU request is withdrawn as soon as it is acknowledged.
  task automatic tick();
    @(negedge clk);
    if (bus.cpu_ack) bus.cpu_req = 1'b0;
  endtask

  // Device side of one frame: waits for request-to-send, then clocks n_edges.
  task automatic dev_xfer(input logic ack_low, input int n_edges,
                          output logic [7:0] b, output logic par, output logic stp,
                          output logic start, output logic inh, output logic seen);
    int w;
    w = 0;
    b = 8'h00; par = 1'b0; stp = 1'b0; start = 1'b1; inh = 1'b0;
    while (!(clk_oe == 1'b0 && dat_oe == 1'b1) && w < INH + 100) begin
      tick();
      w++;
    end
    seen  = (w < INH + 100);
    start = ps2_dat_sync;
    inh   = bus.rx_inhibit;
    for (int n = 1; n <= n_edges; n++) begin
      repeat (4) tick();
      if (n == 11) dev_dat = ~ack_low;
      dev_clk = 1'b0;
      repeat (5) tick();
      if (n <= 8)       b[n-1] = ps2_dat_sync;
      else if (n == 9)  par    = ps2_dat_sync;
      else if (n == 10) stp    = ps2_dat_sync;
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    repeat (2) tick();
  endtask

  // Full 11-edge frame with checks on every field the device observed.
  task automatic xfer_chk(input string tag, input logic ack_low,
                          input logic [7:0] exp_b, input logic exp_par);
    logic [7:0] b;
    logic par, stp, start, inh, seen;
    dev_xfer(ack_low, 11, b, par, stp, start, inh, seen);
    chk({tag, "_rts"},    seen,  1'b1);
    chk({tag, "_start"},  start, 1'b0);
    chk({tag, "_rxinh"},  inh,   1'b1);
    chk({tag, "_byte"},   b,     exp_b);
    chk({tag, "_parity"}, par,   exp_par);
    chk({tag, "_stop"},   stp,   1'b1);
  endtask

  task automatic reply(input logic [7:0] code);
    tick();
    bus.rx_code  = code;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic start_cpu(input logic [7:0] c);
    int w;
    w = 0;
    bus.cpu_cmd = c;
    bus.cpu_req = 1'b1;
    while (bus.cpu_req && w < 50) begin
      tick();
      w++;
    end
    chk("cpu_ack_seen", bus.cpu_req, 1'b0);
  endtask

  initial begin
    int d0, e0, a0, cnt;
    logic [7:0] b;
    logic par, stp, start, inh, seen;

    rst = 1'b1;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    bus.cpu_req  = 1'b0;
    bus.cpu_cmd  = 8'h00;
    bus.led_req  = 1'b0;
    bus.led_val  = 3'b000;
    bus.rx_valid = 1'b0;
    bus.rx_code  = 8'h00;
    repeat (3) tick();

    // Reset state
    chk("rst_clk_oe",   clk_oe,         1'b0);
    chk("rst_dat_oe",   dat_oe,         1'b0);
    chk("rst_busy",     bus.busy,       1'b0);
    chk("rst_rxinh",    bus.rx_inhibit, 1'b0);
    chk("rst_err_code", bus.err_code,   2'd0);
    chk("rst_done",     bus.done,       1'b0);
    chk("rst_err",      bus.err,        1'b0);
    chk("rst_cpu_ack",  bus.cpu_ack,    1'b0);
    rst = 1'b0;
    repeat (3) tick();

    // 1: CPU command 0xF4, ACK, 0xFA
    d0 = n_done; e0 = n_err; a0 = n_ack;
    start_cpu(8'hF4);
    chk("t1_busy_acc", bus.busy, 1'b1);
    xfer_chk("t1", 1'b1, 8'hF4, 1'b0);
    chk("t1_busy_wait", bus.busy, 1'b1);
    chk("t1_rxinh_wait", bus.rx_inhibit, 1'b0);
    reply(8'hFA);
    repeat (2) tick();
    chk("t1_done_cnt", n_done - d0, 1);
    chk("t1_ack_cnt",  n_ack - a0,  1);
    chk("t1_err_cnt",  n_err - e0,  0);
    chk("t1_busy_end", bus.busy,    1'b0);
    chk("t1_clk_oe",   clk_oe,      1'b0);

    // 2: LED update {caps}=1 -> 0xED, 0x04
    d0 = n_done; e0 = n_err; a0 = n_ack;
    bus.led_val = 3'b100;
    bus.led_req = 1'b1;
    tick();
    bus.led_req = 1'b0;
    xfer_chk("t2a", 1'b1, 8'hED, 1'b1);
    reply(8'hFA);
    chk("t2_done_mid", n_done - d0, 0);
    xfer_chk("t2b", 1'b1, 8'h04, 1'b0);
    reply(8'hFA);
    repeat (10) tick();
    chk("t2_done_cnt", n_done - d0, 1);
    chk("t2_ack_cnt",  n_ack - a0,  0);
    chk("t2_no_repeat_busy", bus.busy, 1'b0);

    // 3: two resends then accepted
    d0 = n_done; e0 = n_err;
    start_cpu(8'hFF);
    xfer_chk("t3a", 1'b1, 8'hFF, 1'b1);
    reply(8'hFE);
    xfer_chk("t3b", 1'b1, 8'hFF, 1'b1);
    reply(8'hFE);
    xfer_chk("t3c", 1'b1, 8'hFF, 1'b1);
    reply(8'hFA);
    repeat (2) tick();
    chk("t3_done_cnt", n_done - d0, 1);
    chk("t3_err_cnt",  n_err - e0,  0);
    chk("t3_err_code", bus.err_code, 2'd0);

    // 4: resend limit exceeded on the fourth 0xFE
    d0 = n_done; e0 = n_err;
    start_cpu(8'hEE);
    for (int i = 0; i < 4; i++) begin
      xfer_chk("t4", 1'b1, 8'hEE, 1'b1);
      if (i == 3) chk("t4_err_before_last", n_err - e0, 0);
      reply(8'hFE);
    end
    repeat (2) tick();
    chk("t4_err_cnt",  n_err - e0,   1);
    chk("t4_done_cnt", n_done - d0,  0);
    chk("t4_err_code", bus.err_code, 2'd2);
    chk("t4_clk_oe",   clk_oe,       1'b0);
    chk("t4_dat_oe",   dat_oe,       1'b0);
    chk("t4_busy",     bus.busy,     1'b0);

    // 5: device stops clocking after edge 5 -> timeout
    e0 = n_err;
    start_cpu(8'hF5);
    dev_xfer(1'b1, 5, b, par, stp, start, inh, seen);
    chk("t5_rts", seen, 1'b1);
    chk("t5_bits_low5", b[4:0], 5'b10101);
    cnt = 0;
    while (!bus.err && cnt < TO + 50) begin
      tick();
      cnt++;
    end
    chk("t5_err_seen",   bus.err, 1'b1);
    chk("t5_tmo_window", (cnt >= TO - 20) && (cnt <= TO), 1'b1);
    chk("t5_err_code",   bus.err_code, 2'd1);
    tick();
    chk("t5_released",   {clk_oe, dat_oe, bus.busy}, 3'b000);
    chk("t5_err_cnt",    n_err - e0, 1);

    // 5b: asynchronous reset in the middle of INHIBIT
    start_cpu(8'h12);
    repeat (3) tick();
    chk("t5b_clk_oe_inh", clk_oe, 1'b1);
    chk("t5b_rxinh_inh",  bus.rx_inhibit, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5b_clk_oe_rst", clk_oe, 1'b0);
    chk("t5b_dat_oe_rst", dat_oe, 1'b0);
    chk("t5b_busy_rst",   bus.busy, 1'b0);
    chk("t5b_rxinh_rst",  bus.rx_inhibit, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("t5b_idle_after", bus.busy, 1'b0);

    // 6: simultaneous LED and CPU requests; CPU byte gets no ACK bit
    d0 = n_done; e0 = n_err; a0 = n_ack;
    tick();
    bus.led_val = 3'b010;
    bus.led_req = 1'b1;
    bus.cpu_cmd = 8'h55;
    bus.cpu_req = 1'b1;
    tick();
    bus.led_req = 1'b0;
    chk("t6_cpu_not_acked", n_ack - a0, 0);
    xfer_chk("t6a", 1'b1, 8'hED, 1'b1);
    reply(8'hFA);
    xfer_chk("t6b", 1'b1, 8'h02, 1'b0);
    reply(8'hFA);
    chk("t6_led_done", n_done - d0, 1);
    xfer_chk("t6c", 1'b0, 8'h55, 1'b1);
    repeat (2) tick();
    chk("t6_ack_cnt",  n_ack - a0,   1);
    chk("t6_err_cnt",  n_err - e0,   1);
    chk("t6_err_code", bus.err_code, 2'd3);
    chk("t6_released", {clk_oe, dat_oe, bus.busy}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
